// File: rtl/acq_pkg.sv
// Shared types and default frame geometry for the four-channel ADC capture sequencer.
package acq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      PRESENT
   } acq_state_e;

   localparam int N_ADC           = 4;
   localparam int DEF_FRAME_BITS  = 16;
   localparam int DEF_LEAD_BITS   = 4;
   localparam int DEF_SAMPLE_BITS = 12;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: after start, produces FRAME_BITS low/high periods of CLK_DIV
// clocks each, with strobes on the edges where SCLK should fall or rise, and done on the last.
module spi_sclk_gen #(
   parameter int CLK_DIV    = 4,
   parameter int FRAME_BITS = 16
) (
   input  logic clk,
   input  logic reset_b,
   input  logic start,
   output logic rise,
   output logic fall,
   output logic done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(FRAME_BITS + 1);

   logic             active;
   logic             level;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             half_end;
   logic             last_bit;

   assign half_end = active && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_bit = (bit_cnt == BIT_W'(FRAME_BITS - 1));
   assign rise     = half_end && !level;
   assign fall     = start || (half_end && level && !last_bit);
   assign done     = half_end && level && last_bit;

   // level mirrors the SCLK the parent registers from the strobes; the frame ends on a high half
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         active  <= 1'b0;
         level   <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (start) begin
         active  <= 1'b1;
         level   <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (half_end) begin
         div_cnt <= '0;
         if (!level) begin
            level <= 1'b1;
         end else if (last_bit) begin
            active <= 1'b0;
         end else begin
            level   <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
         end
      end else if (active) begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Periodic simultaneous capture from four serial ADCs, presented as one 48-bit set over valid/ready.
// Optional ADC_FRAME_STAMP_EN adds frame_stamp, a per-tick sequence number latched with each set.
module adc_capture_sequencer
   import acq_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int FRAME_BITS    = DEF_FRAME_BITS,
   parameter int LEAD_BITS     = DEF_LEAD_BITS,
   parameter int SAMPLE_BITS   = DEF_SAMPLE_BITS,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic                         clk,
   input  logic                         reset_b,
   input  logic                         enable,
   input  logic [N_ADC-1:0]             adc_miso,
   output logic [N_ADC-1:0]             adc_cs_n,
   output logic                         adc_sclk,
   output logic [N_ADC*SAMPLE_BITS-1:0] sample_data,
   output logic                         sample_valid,
   input  logic                         sample_ready,
   output logic                         busy,
   output logic                         overrun,
   input  logic                         overrun_clr
`ifdef ADC_FRAME_STAMP_EN
   ,
   output logic [15:0]                  frame_stamp
`endif
);

   localparam int KEEP_W = FRAME_BITS - LEAD_BITS;
   localparam int PER_W  = $clog2(SAMPLE_PERIOD);
   localparam int PH_W   = $clog2(CLK_DIV);

   acq_state_e        state;
   acq_state_e        state_nxt;
   logic [PER_W-1:0]  per_cnt;
   logic [PH_W-1:0]   ph_cnt;
   logic              tick;
   logic              ph_last;
   logic              start_shift;
   logic              set_overrun;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              frame_done;
   logic [KEEP_W-1:0] shreg [N_ADC];

   assign tick    = enable && (per_cnt == PER_W'(SAMPLE_PERIOD - 1));
   assign ph_last = (ph_cnt == PH_W'(CLK_DIV - 1));

   spi_sclk_gen #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BITS (FRAME_BITS)
   ) u_sclk_gen (
      .clk     (clk),
      .reset_b (reset_b),
      .start   (start_shift),
      .rise    (sclk_rise),
      .fall    (sclk_fall),
      .done    (frame_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_b || !enable) begin
         per_cnt <= '0;
      end else if (tick) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      start_shift = 1'b0;
      set_overrun = 1'b0;
      adc_cs_n    = '1;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (enable) state_nxt = WAIT;
         end
         WAIT: begin
            busy = 1'b0;
            if (!enable) begin
               state_nxt = IDLE;
            end else if (tick) begin
               if (sample_valid) set_overrun = 1'b1;
               else              state_nxt   = CS_SETUP;
            end
         end
         CS_SETUP: begin
            adc_cs_n = '0;
            if (ph_last) begin
               state_nxt   = SHIFT;
               start_shift = 1'b1;
            end
         end
         SHIFT: begin
            adc_cs_n = '0;
            if (frame_done) state_nxt = CS_HOLD;
         end
         CS_HOLD: begin
            adc_cs_n = '0;
            if (ph_last) state_nxt = PRESENT;
         end
         PRESENT: begin
            state_nxt = enable ? WAIT : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ph_cnt restarts on every state change, so it times CS_SETUP and CS_HOLD from their first cycle
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state        <= IDLE;
         ph_cnt       <= '0;
         adc_sclk     <= 1'b1;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         overrun      <= 1'b0;
      end else begin
         state  <= state_nxt;
         ph_cnt <= (state_nxt != state) ? '0 : ph_cnt + 1'b1;
         if (sclk_rise)      adc_sclk <= 1'b1;
         else if (sclk_fall) adc_sclk <= 1'b0;
         if (state == PRESENT) begin
            sample_valid <= 1'b1;
            for (int i = 0; i < N_ADC; i++) begin
               sample_data[i*SAMPLE_BITS +: SAMPLE_BITS] <= shreg[i][SAMPLE_BITS-1:0];
            end
         end else if (sample_ready) begin
            sample_valid <= 1'b0;
         end
         if (set_overrun)      overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

   // Only the trailing KEEP_W bits are retained; the leading bits fall off the top while shifting
   always_ff @(posedge clk) begin
      if (sclk_rise) begin
         for (int i = 0; i < N_ADC; i++) begin
            shreg[i] <= {shreg[i][KEEP_W-2:0], adc_miso[i]};
         end
      end
   end

`ifdef ADC_FRAME_STAMP_EN
   logic [15:0] stamp_cnt;

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         stamp_cnt   <= '0;
         frame_stamp <= '0;
      end else if (state == PRESENT) begin
         frame_stamp <= stamp_cnt;
         stamp_cnt   <= stamp_cnt + 1'b1;
      end else if (set_overrun) begin
         stamp_cnt <= stamp_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: behavioural ADC models plus a frame scoreboard.
module tb_adc_capture_sequencer;

   localparam int P   = 200;
   localparam int CD  = 4;
   localparam int FB  = 16;
   localparam int LAT = 1 + CD * (2 + 2 * FB) + 1;

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  adc_miso = '0;
   logic [3:0]  adc_cs_n;
   logic        adc_sclk;
   logic [47:0] sample_data;
   logic        sample_valid;
   logic        sample_ready = 1'b0;
   logic        busy;
   logic        overrun;
   logic        overrun_clr = 1'b0;
`ifdef ADC_FRAME_STAMP_EN
   logic [15:0] frame_stamp;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // ADC model state and scoreboard
   bit          rand_mode = 1'b0;
   logic [15:0] fix_frame [4];
   logic [15:0] cur_frame [4];
   logic [47:0] exp_q [$];
   int          cs_fall_q [$];
   int          rise_cnt = 0;
   int          frame_rises = 0;
   logic [3:0]  prev_cs = 4'hF;
   logic        prev_sclk = 1'b1;

   adc_capture_sequencer #(
      .CLK_DIV       (CD),
      .FRAME_BITS    (FB),
      .LEAD_BITS     (4),
      .SAMPLE_BITS   (12),
      .SAMPLE_PERIOD (P)
   ) dut (
      .clk          (clk),
      .reset_b      (reset_b),
      .enable       (enable),
      .adc_miso     (adc_miso),
      .adc_cs_n     (adc_cs_n),
      .adc_sclk     (adc_sclk),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .busy         (busy),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
`ifdef ADC_FRAME_STAMP_EN
      ,
      .frame_stamp  (frame_stamp)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Each ADC latches a new frame when CS falls and shifts it out MSB first, one bit per SCLK rise
   always @(negedge clk) begin
      logic [47:0] e;
      if (adc_cs_n == 4'h0 && prev_cs != 4'h0) begin
         cs_fall_q.push_back(cyc);
         for (int i = 0; i < 4; i++) cur_frame[i] = rand_mode ? 16'($urandom) : fix_frame[i];
         for (int i = 0; i < 4; i++) e[i*12 +: 12] = cur_frame[i][11:0];
         exp_q.push_back(e);
         rise_cnt = 0;
      end
      if (adc_cs_n == 4'h0 && adc_sclk && !prev_sclk) rise_cnt++;
      if (adc_cs_n == 4'hF && prev_cs == 4'h0) frame_rises = rise_cnt;
      for (int i = 0; i < 4; i++) begin
         if (adc_cs_n == 4'h0 && rise_cnt < 16) adc_miso[i] = cur_frame[i][15 - rise_cnt];
         else adc_miso[i] = 1'b0;
      end
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
   end

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_valid(input int budget, output int at_cyc, output bit ok);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_valid && n < budget);
      ok = sample_valid;
      at_cyc = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      enable = 1'b0;
      sample_ready = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || sample_valid) && n < 500);
      total++;
      if (busy || sample_valid) begin
         bad++;
         $display("FAIL idle_timeout: busy=%0b valid=%0b, required both 0", busy, sample_valid);
      end
      repeat (3) @(negedge clk);
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset_b = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (adc_cs_n !== 4'hF) begin bad++; $display("FAIL reset_cs_n: got %h want F", adc_cs_n); end
      total++; if (adc_sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk: got %b want 1", adc_sclk); end
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
      total++; if (sample_data !== 48'h0) begin bad++; $display("FAIL reset_data: got %h want 0", sample_data); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_bit_mapping();
      int c0, t1, vc, n0;
      bit ok;
      exp_q.delete();
      rand_mode = 1'b0;
      fix_frame[0] = 16'h0ABC; fix_frame[1] = 16'h0123;
      fix_frame[2] = 16'h0FFF; fix_frame[3] = 16'h0000;
      sample_ready = 1'b1;
      n0 = cs_fall_q.size();
      c0 = cyc; t1 = c0 + P - 1;
      enable = 1'b1;
      wait_valid(P + LAT + 20, vc, ok);
      total++; if (!ok || vc != t1 + LAT) begin bad++; $display("FAIL map_latency: valid at %0d (seen=%0b), want %0d", vc, ok, t1 + LAT); end
      total++; if (sample_data !== 48'h000_FFF_123_ABC) begin bad++; $display("FAIL map_data: got %h want 000fff123abc", sample_data); end
      total++; if (cs_fall_q.size() <= n0 || cs_fall_q[n0] != t1 + 1) begin bad++; $display("FAIL map_cs_fall: falls=%0d, want first at %0d", cs_fall_q.size() - n0, t1 + 1); end
      total++; if (frame_rises != FB) begin bad++; $display("FAIL map_sclk_rises: got %0d want %0d", frame_rises, FB); end
      @(negedge clk);
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL map_valid_clear: got %b want 0", sample_valid); end
      wait_idle();
   endtask

   task automatic test_lead_bits();
      int vc;
      bit ok;
      exp_q.delete();
      rand_mode = 1'b0;
      for (int i = 0; i < 4; i++) fix_frame[i] = 16'hF555;
      sample_ready = 1'b1;
      enable = 1'b1;
      wait_valid(P + LAT + 20, vc, ok);
      total++; if (!ok || sample_data !== 48'h555_555_555_555) begin bad++; $display("FAIL lead_bits: got %h (seen=%0b) want 555555555555", sample_data, ok); end
      wait_idle();
   endtask

   task automatic test_backpressure();
      int c0, t1, vc, n0;
      bit ok;
      logic [47:0] d1, e;
      exp_q.delete();
      rand_mode = 1'b1;
      sample_ready = 1'b0;
      overrun_clr = 1'b0;
      n0 = cs_fall_q.size();
      c0 = cyc; t1 = c0 + P - 1;
      enable = 1'b1;
      wait_valid(P + LAT + 20, vc, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hX;
      d1 = sample_data;
      total++; if (!ok || vc != t1 + LAT) begin bad++; $display("FAIL bp_latency: valid at %0d (seen=%0b), want %0d", vc, ok, t1 + LAT); end
      total++; if (d1 !== e) begin bad++; $display("FAIL bp_data: got %h want %h", d1, e); end
      wait_until(t1 + P - 2);
      overrun_clr = 1'b1;
      wait_until(t1 + P + 1);
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_set_wins: got %b want 1", overrun); end
      total++; if (sample_valid !== 1'b1 || sample_data !== d1) begin bad++; $display("FAIL bp_hold: valid=%b data=%h, want 1 and %h", sample_valid, sample_data, d1); end
      overrun_clr = 1'b0;
      wait_until(t1 + P + 20);
      total++; if (cs_fall_q.size() != n0 + 1 || adc_cs_n !== 4'hF) begin bad++; $display("FAIL bp_no_cs: falls=%0d cs_n=%h, want 1 and F", cs_fall_q.size() - n0, adc_cs_n); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky: got %b want 1", overrun); end
      sample_ready = 1'b1;
      overrun_clr = 1'b1;
      @(negedge clk);
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL bp_accept: valid=%b want 0", sample_valid); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_overrun_clr: got %b want 0", overrun); end
      overrun_clr = 1'b0;
      wait_idle();
   endtask

   task automatic test_enable_drop();
      int c0, t1, vc, n0, nv;
      bit ok;
      logic [47:0] e;
      exp_q.delete();
      rand_mode = 1'b1;
      sample_ready = 1'b1;
      n0 = cs_fall_q.size();
      c0 = cyc; t1 = c0 + P - 1;
      enable = 1'b1;
      wait_until(t1 + 1 + CD + 10);
      enable = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy: got %b want 1", busy); end
      wait_valid(LAT + 20, vc, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hX;
      total++; if (!ok || vc != t1 + LAT || sample_data !== e) begin bad++; $display("FAIL drop_present: at %0d data %h (seen=%0b), want %0d %h", vc, sample_data, ok, t1 + LAT, e); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle: busy=%b want 0", busy); end
      nv = 0;
      repeat (3 * P) begin
         @(negedge clk);
         if (sample_valid) nv++;
      end
      total++; if (cs_fall_q.size() != n0 + 1 || nv > 1) begin bad++; $display("FAIL drop_quiet: falls=%0d valid_cycles=%0d, want 1 and <=1", cs_fall_q.size() - n0, nv); end
      wait_idle();
   endtask

   task automatic test_reset_mid_shift();
      int c0, t1, n0, nv;
      rand_mode = 1'b1;
      sample_ready = 1'b1;
      c0 = cyc; t1 = c0 + P - 1;
      enable = 1'b1;
      wait_until(t1 + 1);
      total++; if (adc_cs_n !== 4'h0) begin bad++; $display("FAIL rst_cs_low: got %h want 0", adc_cs_n); end
      wait_until(t1 + 1 + 40);
      reset_b = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      total++; if (adc_cs_n !== 4'hF || adc_sclk !== 1'b1 || sample_valid !== 1'b0) begin bad++; $display("FAIL rst_abort: cs_n=%h sclk=%b valid=%b, want F 1 0", adc_cs_n, adc_sclk, sample_valid); end
      reset_b = 1'b1;
      exp_q.delete();
      n0 = cs_fall_q.size();
      nv = 0;
      repeat (3 * P) begin
         @(negedge clk);
         if (sample_valid) nv++;
      end
      total++; if (nv != 0 || cs_fall_q.size() != n0) begin bad++; $display("FAIL rst_quiet: valid_cycles=%0d falls=%0d, want 0 0", nv, cs_fall_q.size() - n0); end
   endtask

   task automatic test_period();
      int c0, t1, vc, n0;
      bit ok;
      logic [47:0] e;
      exp_q.delete();
      rand_mode = 1'b1;
      sample_ready = 1'b1;
      n0 = cs_fall_q.size();
      c0 = cyc; t1 = c0 + P - 1;
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_valid(P + LAT + 20, vc, ok);
         if (k == 4) enable = 1'b0;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hX;
         total++; if (!ok || vc != t1 + k * P + LAT) begin bad++; $display("FAIL period_valid_%0d: at %0d (seen=%0b) want %0d", k, vc, ok, t1 + k * P + LAT); end
         total++; if (sample_data !== e) begin bad++; $display("FAIL period_data_%0d: got %h want %h", k, sample_data, e); end
         total++; if (cs_fall_q.size() <= n0 + k || cs_fall_q[n0 + k] != t1 + k * P + 1) begin bad++; $display("FAIL period_start_%0d: falls=%0d, want start at %0d", k, cs_fall_q.size() - n0, t1 + k * P + 1); end
`ifdef ADC_FRAME_STAMP_EN
         total++; if (frame_stamp !== 16'(k)) begin bad++; $display("FAIL period_stamp_%0d: got %0d want %0d", k, frame_stamp, k); end
`endif
      end
      repeat (P + 20) @(negedge clk);
      total++; if (cs_fall_q.size() != n0 + 5) begin bad++; $display("FAIL period_count: got %0d sets want 5", cs_fall_q.size() - n0); end
      wait_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout: bench did not reach summary, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_bit_mapping();
      test_lead_bits();
      test_backpressure();
      test_enable_drop();
      test_reset_mid_shift();
      test_period();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
Sequences simultaneous conversions on the four serial ADCs (one shared SCLK, four MISO lines) at a fixed sample rate. Generates chip-selects and SCLK, deserialises four 16-bit frames and extracts the 12-bit results. Presents one 48-bit sample set per conversion to the downstream buffer/UART path through a valid/ready handshake. Flags overruns when downstream stalls.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
FRAME_BITS, 16, SCLK cycles per conversion frame
LEAD_BITS, 4, leading zero bits discarded at frame start
SAMPLE_BITS, 12, result bits kept (LEAD_BITS+SAMPLE_BITS <= FRAME_BITS)
SAMPLE_PERIOD, 1000, clk cycles between conversion starts (> frame time + 2*CLK_DIV + 2)

Ports:
clk  in  1  system clock
reset_b  in  1  synchronous active-low reset
enable  in  1  run sample timer; low = finish current frame, then idle
adc_miso  in  4  serial data, bit i from ADC i+1
adc_cs_n  out  4  chip selects, all driven identically
adc_sclk  out  1  serial clock, idle high
sample_data  out  48  {ch4,ch3,ch2,ch1}, 12 bits each, ch1 in [11:0]
sample_valid  out  1  sample_data holds an unaccepted set
sample_ready  in  1  downstream accepts when valid&ready
busy  out  1  high in any state except IDLE/WAIT
overrun  out  1  sticky: a conversion tick found sample_valid still high
overrun_clr  in  1  clears overrun (set has priority if same cycle)

Behaviour:
- Reset (reset_b=0 at clk edge): state IDLE, adc_cs_n=4'hF, adc_sclk=1, sample_valid=0, sample_data=0, overrun=0, busy=0, period counter=0. Reset mid-frame aborts immediately. CS rises on that edge; no partial data is presented.
- Period counter: runs while enable=1 and counts 0..SAMPLE_PERIOD-1. The tick is count==SAMPLE_PERIOD-1 and wraps to 0. Counter held at 0 while enable=0.
- FSM states:
  - IDLE: move to WAIT when enable=1.
  - WAIT: on tick, if sample_valid=1 then set overrun, skip the conversion and stay in WAIT. Otherwise go to CS_SETUP. enable=0 returns to IDLE.
  - CS_SETUP: adc_cs_n=0, sclk high, lasts CLK_DIV cycles.
  - SHIFT: FRAME_BITS SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - adc_miso is registered into the four shift registers on the clk edge that drives sclk low->high, MSB first.
  - CS_HOLD: sclk high, cs_n stays 0 for CLK_DIV cycles, then cs_n=1.
  - PRESENT: load sample_data with shift bits [SAMPLE_BITS-1:0] of each channel (leading bits dropped). Set sample_valid. Go to WAIT, or IDLE if enable=0.
- Conversion latency: tick to sample_valid = 1 + CLK_DIV*(2+2*FRAME_BITS) + 1 clk. Default = 138 cycles.
- Handshake: sample_valid clears on the cycle after valid&ready. sample_data is stable while valid=1. Ready with valid=0 is ignored.
- enable deassert mid-frame: the frame completes and is presented. No new tick is taken.
- overrun: set on a skipped tick, cleared by overrun_clr. If both occur in the same cycle, it stays set.

Optional Feature:
ADC_FRAME_STAMP_EN
- Defined: adds output frame_stamp[15:0], latched with sample_data. It holds a free-running count of completed conversions: reset 0, +1 per PRESENT, wraps 16'hFFFF->0. Skipped ticks also increment a hidden counter so gaps are visible, i.e. stamp = tick count.
- Undefined: port and counters absent, behaviour otherwise identical.

Decomposition:
- Shared package acq_pkg holds:
  - the FSM state enum (IDLE, WAIT, CS_SETUP, SHIFT, CS_HOLD, PRESENT)
  - N_ADC=4
  - default FRAME_BITS, LEAD_BITS and SAMPLE_BITS
- One natural sub-module: spi_sclk_gen. It is a CLK_DIV half-period divider with start/done and rise/fall strobes, instantiated once by the FSM.

Test Plan:
- Reset mid-SHIFT (reset_b=0 at cycle 40 after CS falls) -> next edge: cs_n=F, sclk=1, valid=0. No sample appears afterwards until enable is re-asserted.
- Bit mapping: ADC models return 0x0ABC, 0x0123, 0x0FFF, 0x0000 with ready=1 -> sample_data=48'h000_FFF_123_ABC, valid at tick+138. SCLK shows exactly 16 rising edges while cs_n=0.
- Leading bits discarded: frame 0xF555 on all channels -> each channel field = 12'h555.
- Backpressure: ready=0 across two ticks -> first set held unchanged, overrun=1 at second tick, no CS activity on second tick. ready=1 then overrun_clr -> valid drops one cycle after accept, overrun=0.
- enable dropped 10 cycles into SHIFT -> frame completes, valid asserts, FSM reaches IDLE, no further cs_n activity over 3*SAMPLE_PERIOD.
- SAMPLE_PERIOD=200, ready=1, 5 periods -> exactly 5 sample sets, starts 200 cycles apart. With ADC_FRAME_STAMP_EN defined, stamps are 0,1,2,3,4.
